// File: rtl/pattern_tx.sv
// pattern_tx: serial MSB-first word transmitter with optional repeats separated by idle gaps.
// Define PATTERN_TX_LOOPBACK_EN to compile in a 10101 loopback detector driving match_cnt.
module pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
`ifdef PATTERN_TX_LOOPBACK_EN
  ,
  output logic [7:0]       match_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_left_q, rep_left_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             start_acc;

  assign start_acc = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      rep_left_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_left_q <= rep_left_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    rep_left_d = rep_left_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          word_d     = data;
          shreg_d    = data;
          rep_left_d = reps;
          bit_cnt_d  = BIT_LAST;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == '0) begin
          if (rep_left_q == '0) begin
            state_d = ST_DONE;
          end else begin
            // Reload happens here so a GAP of zero can go straight back to SHIFT.
            rep_left_d = rep_left_q - 1'b1;
            shreg_d    = word_q;
            bit_cnt_d  = BIT_LAST;
            if (GAP == 0) begin
              state_d = ST_SHIFT;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LAST;
            end
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign x       = (state_q == ST_SHIFT) & shreg_q[WIDTH-1];
  assign x_valid = (state_q == ST_SHIFT);
  assign busy    = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign done    = (state_q == ST_DONE);
  assign state   = state_q;

`ifdef PATTERN_TX_LOOPBACK_EN
  typedef enum logic [2:0] {
    D_NONE  = 3'd0,
    D_1     = 3'd1,
    D_10    = 3'd2,
    D_101   = 3'd3,
    D_1010  = 3'd4
  } det_e;

  det_e       det_q, det_d;
  logic       hit;
  logic [7:0] match_cnt_q;

  // Overlapping detector: a hit in D_1010 falls back to D_101 so 1010101 counts twice.
  always_comb begin
    det_d = det_q;
    hit   = 1'b0;
    if (x_valid) begin
      case (det_q)
        D_NONE: det_d = x ? D_1 : D_NONE;
        D_1:    det_d = x ? D_1 : D_10;
        D_10:   det_d = x ? D_101 : D_NONE;
        D_101:  det_d = x ? D_1 : D_1010;
        D_1010: begin
          if (x) begin
            det_d = D_101;
            hit   = 1'b1;
          end else begin
            det_d = D_NONE;
          end
        end
        default: det_d = D_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_q       <= D_NONE;
      match_cnt_q <= '0;
    end else if (start_acc) begin
      det_q       <= D_NONE;
      match_cnt_q <= '0;
    end else begin
      det_q <= det_d;
      if (hit && (match_cnt_q != 8'hFF)) begin
        match_cnt_q <= match_cnt_q + 8'd1;
      end
    end
  end

  assign match_cnt = match_cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: stimulus pushes expected serial bits, a monitor pops them on x_valid.
module tb_pattern_tx;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] reps;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [1:0]       state;
`ifdef PATTERN_TX_LOOPBACK_EN
  logic [7:0]       match_cnt;
`endif

  int   n_total = 0;
  int   n_pass  = 0;
  logic exp_q[$];

  pattern_tx #(
    .WIDTH(WIDTH),
    .GAP  (GAP),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .reps     (reps),
    .x        (x),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done),
    .state    (state)
`ifdef PATTERN_TX_LOOPBACK_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  // Start is presented for exactly one rising edge (E0); returns just after E0.
  task automatic launch(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] r);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    reps  = r;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (x_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 32'(x), 32'hDEAD);
      end else begin
        check("serial_bit", 32'(x), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    data  = '0;
    reps  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_state", 32'(state), 32'd0);

    // Single word A8, no repeats
    push_word(8'hA8);
    launch(8'hA8, 4'd0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("t1_valid", 32'(x_valid), 32'(c <= 8));
      check("t1_done", 32'(done), 32'(c == 9));
      if (c == 10) check("t1_idle", 32'(state), 32'd0);
    end
    check("t1_drained", 32'(exp_q.size()), 32'd0);
`ifdef PATTERN_TX_LOOPBACK_EN
    check("t1_match", 32'(match_cnt), 32'd1);
`endif

    // 55 with two repeats, gap of two
    for (int k = 0; k < 3; k++) push_word(8'h55);
    launch(8'h55, 4'd2);
    for (int c = 1; c <= 31; c++) begin
      automatic bit gap_c = (c == 9) || (c == 10) || (c == 19) || (c == 20);
      automatic bit vld   = (c <= 28) && !gap_c;
      @(negedge clk);
      check("t2_valid", 32'(x_valid), 32'(vld));
      if (!vld) check("t2_x_idle", 32'(x), 32'd0);
      if (gap_c) check("t2_gap_state", 32'(state), 32'd2);
      check("t2_busy", 32'(busy), 32'(c <= 28));
      check("t2_done", 32'(done), 32'(c == 29));
    end
    check("t2_drained", 32'(exp_q.size()), 32'd0);
`ifdef PATTERN_TX_LOOPBACK_EN
    check("t2_match", 32'(match_cnt), 32'd10);
`endif

    // start pulsed in SHIFT (cycle 4, with new data) and in DONE (cycle 9)
    push_word(8'hA8);
    launch(8'hA8, 4'd0);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      check("t3_busy", 32'(busy), 32'(c <= 8));
      check("t3_done", 32'(done), 32'(c == 9));
      if (c >= 10) check("t3_idle", 32'(state), 32'd0);
      start = (c == 4) || (c == 9);
      if (c == 4) begin
        data = 8'hFF;
        reps = 4'd3;
      end
    end
    start = 1'b0;
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in cycle 4
    push_word(8'hA8);
    for (int k = 0; k < 5; k++) void'(exp_q.pop_back());
    launch(8'hA8, 4'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t4_state", 32'(state), 32'd0);
    check("t4_x", 32'(x), 32'd0);
    check("t4_valid", 32'(x_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
`ifdef PATTERN_TX_LOOPBACK_EN
    check("t4_match", 32'(match_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    push_word(8'hC3);
    launch(8'hC3, 4'd0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("t4_fresh_valid", 32'(x_valid), 32'(c <= 8));
      check("t4_fresh_done", 32'(done), 32'(c == 9));
    end
    check("t4_fresh_drained", 32'(exp_q.size()), 32'd0);
`ifdef PATTERN_TX_LOOPBACK_EN
    check("t4_fresh_match", 32'(match_cnt), 32'd0);
`endif

    // start held high: back-to-back FF transfers
    push_word(8'hFF);
    push_word(8'hFF);
    @(negedge clk);
    start = 1'b1;
    data  = 8'hFF;
    reps  = 4'd0;
    @(posedge clk);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check("t5_busy", 32'(busy), 32'((c <= 8) || (c >= 11 && c <= 18)));
      check("t5_done", 32'(done), 32'((c == 9) || (c == 19)));
      if (c == 11) check("t5_first_bit", 32'(x), 32'd1);
      if (c == 20) check("t5_idle", 32'(state), 32'd0);
      if (c == 12) start = 1'b0;
    end
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

- Serial pattern transmitter: loads a WIDTH-bit word and drives it MSB-first onto a one-bit serial line `x`, one bit per clock.
- Optionally repeats the word with idle gaps between copies.
- Sits upstream of the team's Mealy sequence detectors as their stimulus and traffic source.
- Exposes its FSM state, and can compile in a loopback checker that counts 10101 occurrences in its own output.

## Interface
- WIDTH, 8, bits per word (≥2)
- GAP, 2, idle cycles between repeated copies (0 = back-to-back)
- CNT_W, 4, width of repeat count
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  transfer request; accepted only in IDLE
- data  in  WIDTH  word to send; captured on accepted start
- reps  in  CNT_W  extra copies after the first; captured on accepted start
- x  out  1  serial bit; 0 whenever x_valid=0
- x_valid  out  1  high in SHIFT
- busy  out  1  high in SHIFT or GAP
- done  out  1  one-cycle pulse in DONE
- state  out  2  current FSM state
- match_cnt  out  8  loopback 10101 count (only with PATTERN_TX_LOOPBACK_EN)

## Operation
- States:
  - IDLE = 2'b00
  - SHIFT = 2'b01
  - GAP = 2'b10
  - DONE = 2'b11
- IDLE:
  - on start=1, capture data into a word register and a shift register.
  - capture reps into rep_left; bit_cnt = WIDTH-1; next state SHIFT.
- SHIFT:
  - x = shreg[WIDTH-1]; shreg shifts left each cycle; bit_cnt decrements.
  - At bit_cnt==0 with rep_left==0, go to DONE.
  - At bit_cnt==0 with rep_left>0:
    - rep_left decrements; reload shreg from the word register; bit_cnt = WIDTH-1.
    - next state GAP with gap_cnt = GAP-1, or SHIFT directly if GAP==0.
- GAP: x=0, x_valid=0; gap_cnt decrements; at gap_cnt==0 go to SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in SHIFT, GAP and DONE; data and reps changes outside an accepted start have no effect.
- All outputs are decoded from registered state and datapath, with no combinational path from any input.
- Reset (asynchronous, any time, including mid-word), all registers cleared:
  - state = IDLE, x = 0, x_valid = 0, busy = 0, done = 0, match_cnt = 0.

## Timing
- Accepted start at edge E0: bit k (k = 0..WIDTH-1) is on x during cycle k+1.
- Single word: done is high in cycle WIDTH+1; IDLE in cycle WIDTH+2.
- With R repeats, done is high in cycle (R+1)·WIDTH + R·GAP + 1.
- Minimum spacing between accepted starts is total length + 2 cycles. With start held high, the next word's first bit follows the previous done by 2 cycles.
- Repeat counter arithmetic is unsigned; reps = 2^CNT_W - 1 is legal and gives 2^CNT_W copies. No wrap occurs.

## Configuration
- PATTERN_TX_LOOPBACK_EN defined:
  - Compiles in a 5-state overlapping Mealy detector for 10101, clocked on x, advancing only when x_valid=1. GAP cycles freeze it.
  - match_cnt increments on each detection and saturates at 255.
  - Detector state and match_cnt clear on accepted start and on reset.
- Undefined: detector logic and the match_cnt port are absent; all other behaviour is identical.

## Test plan
- Reset with WIDTH=8: hold reset=0 for 3 cycles, then release.
  - Expect state=00, x=0, busy=0, done=0.
- Single word, reps=0: start with data=8'hA8.
  - Expect x = 1,0,1,0,1,0,0,0 in cycles 1–8 with x_valid=1.
  - Expect done=1 in cycle 9 only; match_cnt=1.
- Repeats with gaps: data=8'h55, reps=2, GAP=2.
  - Expect 24 valid bits (alternating 0/1), with x_valid=0 and x=0 in cycles 9–10 and 19–20.
  - Expect done in cycle 29; match_cnt=10.
- start pulsed during SHIFT and during DONE.
  - Expect it ignored: no change to the bit stream, and the next transfer is not triggered.
- reset asserted in cycle 4 of a transfer.
  - Expect all outputs 0 and state IDLE immediately (asynchronous).
  - Expect a new start after release to transmit a full fresh word.
- start held high with data=8'hFF, reps=0.
  - Expect back-to-back transfers with done at cycle 9, next first bit at cycle 11, and busy low in cycles 9–10.
